// File: rtl/fb_scanout.sv
`default_nettype none
// ============================================================================
// Module   : fb_scanout
// Purpose  : Framebuffer read side and VGA timing generator. Walks the raster
//            one pixel per CLK_DIV clocks, issues one framebuffer read per
//            visible pixel and turns the returned RGB565 word into 4:4:4
//            colour. Sync outputs are aligned with the colour.
// Ports    : clk, rstn (async, active low)
//            src_addr/src_rd/src_data : framebuffer read port
//            test_en                  : colour-bar select (optional feature)
//            vga_r/g/b, vga_hs/vs     : VGA pins (syncs active low)
//            frame_start              : pulse with the read of pixel (0,0)
//            in_vblank                : line counter >= V_ACTIVE
// Options  : `define SCANOUT_TEST_PATTERN_EN builds the colour-bar generator;
//            without it test_en is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module fb_scanout #(
  parameter int CLK_DIV  = 4,
  parameter int RD_LAT   = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [18:0] src_addr,
  output logic        src_rd,
  input  logic [15:0] src_data,
  input  logic        test_en,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_start,
  output logic        in_vblank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLK_DIV - 1);
  localparam logic [HW-1:0]    c_h_act    = HW'(H_ACTIVE);
  localparam logic [HW-1:0]    c_h_last   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]    c_hs_beg   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]    c_hs_end   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0]    c_v_act    = VW'(V_ACTIVE);
  localparam logic [VW-1:0]    c_v_last   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]    c_vs_beg   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]    c_vs_end   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0]  r_div;
  logic [HW-1:0]     r_h;
  logic [HW-1:0]     r_h_d;
  logic [VW-1:0]     r_v;
  logic [VW-1:0]     r_v_d;
  logic [18:0]       r_lin;
  logic              r_act_d;
  logic [RD_LAT-1:0] r_rd_pipe;
  logic [11:0]       r_hold;

  logic        w_tick;
  logic        w_active;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_fetch;
  logic [11:0] w_rgb_in;
  logic [11:0] w_pix;
  logic [11:0] w_colour;
  logic        w_unused;

  assign w_tick    = (r_div == c_div_last);
  assign w_h_last  = (r_h == c_h_last);
  assign w_v_last  = (r_v == c_v_last);
  assign w_active  = (r_h < c_h_act) && (r_v < c_v_act);
  assign in_vblank = (r_v >= c_v_act);

  // RGB565 -> 4:4:4 by taking the top four bits of each channel
  assign w_rgb_in = {src_data[15:12], src_data[10:7], src_data[4:1]};

  // When RD_LAT == CLK_DIV-1 the data lands on the output tick itself, so it
  // is taken straight from the bus instead of the hold register.
  assign w_pix = r_rd_pipe[RD_LAT-1] ? w_rgb_in : r_hold;

`ifdef SCANOUT_TEST_PATTERN_EN
  logic [2:0]  w_bar;
  logic [11:0] w_bar_rgb;

  always_comb begin
    w_bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(r_h_d) >= k * 80) w_bar = 3'(k);
    end
  end

  // Bar order white, yellow, cyan, green, magenta, red, blue, black falls
  // out of the index bits: red = ~b1, green = ~b2, blue = ~b0.
  assign w_bar_rgb = {{4{~w_bar[1]}}, {4{~w_bar[2]}}, {4{~w_bar[0]}}};
  assign w_fetch   = ~test_en;
  assign w_colour  = !r_act_d ? 12'h000 : (test_en ? w_bar_rgb : w_pix);
  assign w_unused  = ^{src_data[11], src_data[6:5], src_data[0]};
`else
  assign w_fetch   = 1'b1;
  assign w_colour  = r_act_d ? w_pix : 12'h000;
  assign w_unused  = ^{test_en, src_data[11], src_data[6:5], src_data[0]};
`endif

  // Pixel-rate divider
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_div <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
    end
  end

  // Raster counters, read issue and the one-tick delayed position/active flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_h         <= '0;
      r_v         <= '0;
      r_h_d       <= '0;
      r_v_d       <= '0;
      r_act_d     <= 1'b0;
      r_lin       <= '0;
      src_addr    <= '0;
      src_rd      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      src_rd      <= 1'b0;
      frame_start <= 1'b0;
      if (w_tick) begin
        if (w_h_last) begin
          r_h <= '0;
          r_v <= w_v_last ? '0 : r_v + 1'b1;
        end else begin
          r_h <= r_h + 1'b1;
        end
        // The linear address follows the raster incrementally; it only has
        // to be rewound once per frame, at the last blanking position.
        if (w_h_last && w_v_last) begin
          r_lin <= '0;
        end else if (w_active) begin
          r_lin <= r_lin + 19'd1;
        end
        if (w_active) begin
          src_addr <= r_lin;
          src_rd   <= w_fetch;
        end
        frame_start <= (r_h == '0) && (r_v == '0);
        r_h_d       <= r_h;
        r_v_d       <= r_v;
        r_act_d     <= w_active;
      end
    end
  end

  // Read-data capture and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_pipe <= '0;
      r_hold    <= '0;
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
      vga_hs    <= 1'b1;
      vga_vs    <= 1'b1;
    end else begin
      r_rd_pipe <= (r_rd_pipe << 1) | RD_LAT'(src_rd);
      if (r_rd_pipe[RD_LAT-1]) r_hold <= w_rgb_in;
      if (w_tick) begin
        {vga_r, vga_g, vga_b} <= w_colour;
        vga_hs <= ~((r_h_d >= c_hs_beg) && (r_h_d <= c_hs_end));
        vga_vs <= ~((r_v_d >= c_vs_beg) && (r_v_d <= c_vs_end));
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_scanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_scanout
// Purpose  : Self-checking bench for fb_scanout. One instance uses the full
//            640x480 timing for line-level behaviour, a second uses a tiny
//            raster so that several whole frames fit in a short run.
//            Expected outputs come from a closed-form model of the raster as
//            a function of clocks elapsed since reset release.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_scanout;

  localparam int B_CD  = 4;
  localparam int B_LAT = 2;
  localparam int S_CD  = 4;
  localparam int S_LAT = 3;
  localparam int S_HA = 16, S_HF = 2, S_HS = 4, S_HB = 3;
  localparam int S_VA = 6,  S_VF = 1, S_VS = 2, S_VB = 2;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
  localparam int S_FR = S_HT * S_VT;

  typedef struct packed {
    logic [18:0] addr;
    logic        rd;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        vb;
  } obs_t;

  typedef struct {
    int cd, ha, hf, hs, hb, va, vf, vs, vb;
  } tim_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn_b, rstn_s, test_b, test_s;
  logic [18:0] b_addr, s_addr;
  logic        b_rd, s_rd;
  logic [15:0] b_data, s_data;
  logic [3:0]  b_r, b_g, b_bl, s_r, s_g, s_bl;
  logic        b_hs, b_vs, b_fs, b_vb, s_hs, s_vs, s_fs, s_vb;
  obs_t        ob_b, ob_s;

  fb_scanout #(.CLK_DIV(B_CD), .RD_LAT(B_LAT)) u_big (
    .clk(clk), .rstn(rstn_b), .src_addr(b_addr), .src_rd(b_rd),
    .src_data(b_data), .test_en(test_b), .vga_r(b_r), .vga_g(b_g),
    .vga_b(b_bl), .vga_hs(b_hs), .vga_vs(b_vs), .frame_start(b_fs),
    .in_vblank(b_vb)
  );

  fb_scanout #(
    .CLK_DIV(S_CD), .RD_LAT(S_LAT),
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
  ) u_small (
    .clk(clk), .rstn(rstn_s), .src_addr(s_addr), .src_rd(s_rd),
    .src_data(s_data), .test_en(test_s), .vga_r(s_r), .vga_g(s_g),
    .vga_b(s_bl), .vga_hs(s_hs), .vga_vs(s_vs), .frame_start(s_fs),
    .in_vblank(s_vb)
  );

  assign ob_b = {b_addr, b_rd, b_r, b_g, b_bl, b_hs, b_vs, b_fs, b_vb};
  assign ob_s = {s_addr, s_rd, s_r, s_g, s_bl, s_hs, s_vs, s_fs, s_vb};

  logic [31:0] seed;

  // Framebuffer contents: fixed red/green at addresses 0/1, hashed elsewhere
  function automatic logic [15:0] memf(int a);
    logic [31:0] x;
    if (a == 0) return 16'hF800;
    if (a == 1) return 16'h07E0;
    x = (32'(a) * 32'h9E3779B1) ^ seed;
    x = x ^ (x >> 13);
    return x[15:0];
  endfunction

  // Framebuffer RAMs: data valid exactly RD_LAT clocks after the strobe,
  // random junk on every other cycle.
  logic [15:0] mem_b [B_LAT];
  logic [15:0] mem_s [S_LAT];
  always @(posedge clk) begin
    mem_b[0] <= b_rd ? memf(int'(b_addr)) : 16'($urandom);
    for (int i = 1; i < B_LAT; i++) mem_b[i] <= mem_b[i-1];
    mem_s[0] <= s_rd ? memf(int'(s_addr)) : 16'($urandom);
    for (int i = 1; i < S_LAT; i++) mem_s[i] <= mem_s[i-1];
  end
  assign b_data = mem_b[B_LAT-1];
  assign s_data = mem_s[S_LAT-1];

  function automatic logic [11:0] to444(logic [15:0] d);
    return {d[15:12], d[10:7], d[4:1]};
  endfunction

  function automatic logic [11:0] bar(int x);
    case (x / 80)
      0:       return 12'hFFF;  // white
      1:       return 12'hFF0;  // yellow
      2:       return 12'h0FF;  // cyan
      3:       return 12'h0F0;  // green
      4:       return 12'hF0F;  // magenta
      5:       return 12'hF00;  // red
      6:       return 12'h00F;  // blue
      default: return 12'h000;  // black
    endcase
  endfunction

  // Expected outputs k clocks after reset release (k = 0: in reset).
  // Pixel n of the run is addressed on clock n*cd+cd and shown one pixel
  // period later; pixel n sits at (n mod H_TOTAL, n div H_TOTAL) of its frame.
  function automatic obs_t model(int k, tim_t p, bit tst);
    int   ht, vt, fr, c, t, ph, pv;
    obs_t o;
    ht = p.ha + p.hf + p.hs + p.hb;
    vt = p.va + p.vf + p.vs + p.vb;
    fr = ht * vt;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    c = k / p.cd;
    o.vb = ((c % fr) / ht) >= p.va;
    if (c >= 1) begin
      t  = (c - 1) % fr;
      ph = t % ht;
      pv = t / ht;
      if (k % p.cd == 0) begin
        o.rd = !tst && ph < p.ha && pv < p.va;
        o.fs = (t == 0);
      end
      // address of the most recent visible pixel y*W + x
      if (pv >= p.va)      o.addr = 19'(p.va * p.ha - 1);
      else if (ph >= p.ha) o.addr = 19'(pv * p.ha + p.ha - 1);
      else                 o.addr = 19'(pv * p.ha + ph);
    end
    if (c >= 2) begin
      t  = (c - 2) % fr;
      ph = t % ht;
      pv = t / ht;
      o.hs = !(ph >= p.ha + p.hf && ph < p.ha + p.hf + p.hs);
      o.vs = !(pv >= p.va + p.vf && pv < p.va + p.vf + p.vs);
      if (ph < p.ha && pv < p.va)
        o.rgb = tst ? bar(ph) : to444(memf(pv * p.ha + ph));
    end
    return o;
  endfunction

  int   checks, errors;
  int   kb, ks, phase;
  tim_t tb_p, ts_p;
  int   b_hs_low;
  bit   b_hs_first;
  int   s_last_fs, s_rd_cnt, s_prev_addr, s_vs_low, s_vb_hi, s_periods;

  task automatic chk_obs(input string tag, input obs_t got, input obs_t exp, input int k);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic bit tst_b_eff();
`ifdef SCANOUT_TEST_PATTERN_EN
    return test_b;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    kb = rstn_b ? kb + 1 : 0;
    ks = rstn_s ? ks + 1 : 0;
    @(negedge clk);
    chk_obs("big", ob_b, model(kb, tb_p, tst_b_eff()), kb);
    chk_obs("small", ob_s, model(ks, ts_p, 1'b0), ks);

    // full-size instance: directed points along the first line
    if (!rstn_b) begin
      b_hs_low   = 0;
      b_hs_first = 1'b1;
    end else begin
      if (phase == 1 && kb == B_CD) begin
        chk_int("first_rd_fs", int'({ob_b.rd, ob_b.fs}), 3);
        chk_int("first_addr", int'(ob_b.addr), 0);
      end
      if (phase == 1 && kb == 2 * B_CD) chk_int("pix0_rgb", int'(ob_b.rgb), 'hF00);
      if (phase == 1 && kb == 3 * B_CD) chk_int("pix1_rgb", int'(ob_b.rgb), 'h0F0);
`ifdef SCANOUT_TEST_PATTERN_EN
      if (phase == 2 && kb == 2 * B_CD)   chk_int("bar_h0", int'(ob_b.rgb), 'hFFF);
      if (phase == 2 && kb == 82 * B_CD)  chk_int("bar_h80", int'(ob_b.rgb), 'hFF0);
      if (phase == 2 && kb == 562 * B_CD) chk_int("bar_h560", int'(ob_b.rgb), 'h000);
`endif
      if (!ob_b.hs) begin
        // 657 ticks after the line's first tick, which is clock B_CD
        if (b_hs_low == 0 && b_hs_first) begin
          chk_int("hs_start", kb, 658 * B_CD);
          b_hs_first = 1'b0;
        end
        b_hs_low++;
      end else if (b_hs_low != 0) begin
        chk_int("hs_width", b_hs_low, 96 * B_CD);
        b_hs_low = 0;
      end
    end

    // small instance: frame-level counts
    if (!rstn_s) begin
      s_last_fs   = -1;
      s_rd_cnt    = 0;
      s_prev_addr = -1;
      s_vs_low    = 0;
      s_vb_hi     = 0;
    end else begin
      if (ob_s.fs) begin
        if (s_last_fs >= 0) begin
          chk_int("fs_period", ks - s_last_fs, S_FR * S_CD);
          chk_int("rd_per_frame", s_rd_cnt, S_HA * S_VA);
          s_periods++;
        end
        s_last_fs = ks;
        s_rd_cnt  = 0;
      end
      if (ob_s.rd) begin
        s_rd_cnt++;
        if (ob_s.addr == 19'd0 && s_prev_addr >= 0)
          chk_int("addr_wrap", s_prev_addr, S_HA * S_VA - 1);
        s_prev_addr = int'(ob_s.addr);
      end
      if (!ob_s.vs) s_vs_low++;
      else if (s_vs_low != 0) begin
        chk_int("vs_width", s_vs_low, S_VS * S_HT * S_CD);
        s_vs_low = 0;
      end
      if (ob_s.vb) s_vb_hi++;
      else if (s_vb_hi != 0) begin
        chk_int("vblank_len", s_vb_hi, (S_VT - S_VA) * S_HT * S_CD);
        s_vb_hi = 0;
      end
    end
  endtask

  initial begin
    int mid_at, s_hold;
    bit did_mid;
    checks = 0; errors = 0; kb = 0; ks = 0; phase = 0;
    s_periods = 0; s_hold = 0; did_mid = 1'b0;
    seed   = $urandom;
    rstn_b = 1'b0; rstn_s = 1'b0; test_b = 1'b0; test_s = 1'b0;
    tb_p = '{B_CD, 640, 16, 96, 48, 480, 10, 2, 33};
    ts_p = '{S_CD, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB};

    // reset held 10 clocks, every cycle checked against reset values
    repeat (10) step();
    rstn_b = 1'b1;
    rstn_s = 1'b1;
    phase  = 1;

    // random visible position in the fourth frame of the small raster
    mid_at = 3 * S_FR * S_CD
           + S_CD * ($urandom_range(S_VA - 1, 1) * S_HT + $urandom_range(S_HA - 1, 1))
           + $urandom_range(S_CD - 1, 0);

    for (int i = 0; i < 1700 * B_CD; i++) begin
      step();
      if (!did_mid && rstn_s && ks == mid_at) begin
        rstn_s  = 1'b0;
        did_mid = 1'b1;
        #1;
        ks = 0;
        chk_obs("small_async_rst", ob_s, model(0, ts_p, 1'b0), ks);
      end else if (!rstn_s) begin
        s_hold++;
        if (s_hold == 5) rstn_s = 1'b1;
      end
      if (errors > 40) break;
    end

    // reset mid-line on the full-size instance, then colour-bar select
    rstn_b = 1'b0;
    #1;
    kb = 0;
    chk_obs("big_async_rst", ob_b, model(0, tb_p, 1'b0), kb);
    test_b = 1'b1;
    repeat (3) step();
    rstn_b = 1'b1;
    phase  = 2;
    for (int i = 0; i < 600 * B_CD; i++) begin
      step();
      if (errors > 40) break;
    end

    chk_int("mid_reset_done", int'(did_mid), 1);
    chk_int("frames_seen", int'(s_periods >= 2), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
